// File: rtl/register_file_sb.sv
// register_file_sb: DEPTH x WIDTH register file with two combinational read
// ports, one synchronous write port and a per-register pending scoreboard.
// Decode reserves destination registers. Writeback writes them and clears
// their pending bit.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the
// read ports. When the macro is undefined, reads see pre-edge state only.

module register_file_sb_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rsv_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q,
    output logic             pend,
    output logic             pend_nxt
);
    // A reserve beats a same-cycle write, because it is the newer producer.
    assign pend_nxt = rsv_en | (pend & ~wr_en);

    // Register data and pending bit. Reset clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            pend <= 1'b0;
        end else begin
            if (wr_en) q <= wr_data;
            pend <= pend_nxt;
        end
    end
endmodule

module register_file_sb #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int AW      = $clog2(DEPTH),
    parameter int ZERO_R0 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_pend_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_pend_b,
    output logic [AW:0]      pend_cnt,
    output logic             any_pend
);
    logic [DEPTH-1:0][WIDTH-1:0] q;
    logic [DEPTH-1:0]            pend;
    logic [DEPTH-1:0]            pend_nxt;
    logic [AW:0]                 cnt_nxt;

    // Register 0 never gets a write or reserve strobe when hard-wired.
    // Its flops therefore hold their reset value of zero.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam bit KEEP = !((ZERO_R0 != 0) && (i == 0));
        logic wr_sel, rsv_sel;
        assign wr_sel  = KEEP && wr_en  && (wr_addr  == AW'(i));
        assign rsv_sel = KEEP && rsv_en && (rsv_addr == AW'(i));
        register_file_sb_cell #(.WIDTH(WIDTH)) u_cell (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_sel),
            .rsv_en  (rsv_sel),
            .wr_data (wr_data),
            .q       (q[i]),
            .pend    (pend[i]),
            .pend_nxt(pend_nxt[i])
        );
    end

    // Popcount of the next pending vector.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end

    // Count and any-pending flag update on the same edge as the pending bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt <= '0;
            any_pend <= 1'b0;
        end else begin
            pend_cnt <= cnt_nxt;
            any_pend <= (cnt_nxt != '0);
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic zero_a, zero_b;
    assign zero_a = (ZERO_R0 != 0) && (rd_addr_a == '0);
    assign zero_b = (ZERO_R0 != 0) && (rd_addr_b == '0);

    // Combinational read ports. A same-cycle writeback is forwarded, and the
    // read shows pending only if a same-cycle reserve targets that register.
    always_comb begin
        rd_data_a = q[rd_addr_a];
        rd_pend_a = pend[rd_addr_a];
        rd_data_b = q[rd_addr_b];
        rd_pend_b = pend[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a) && !zero_a) begin
            rd_data_a = wr_data;
            rd_pend_a = rsv_en && (rsv_addr == rd_addr_a);
        end
        if (wr_en && (wr_addr == rd_addr_b) && !zero_b) begin
            rd_data_b = wr_data;
            rd_pend_b = rsv_en && (rsv_addr == rd_addr_b);
        end
    end
`else
    // Combinational read ports that return pre-edge state.
    always_comb begin
        rd_data_a = q[rd_addr_a];
        rd_pend_a = pend[rd_addr_a];
        rd_data_b = q[rd_addr_b];
        rd_pend_b = pend[rd_addr_b];
    end
`endif
endmodule

// File: tb/tb_register_file_sb.sv
// Randomized plus directed bench for register_file_sb.
// It uses a behavioural array model of the register file and scoreboard.
module tb_register_file_sb;
    localparam int W = 16;
    localparam int D = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0, rsv_en = 1'b0;
    logic [A-1:0] wr_addr = '0, rsv_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] rd_data_a, rd_data_b;
    logic         rd_pend_a, rd_pend_b, any_pend;
    logic [A:0]   pend_cnt;

    int errs = 0;
    int checks = 0;

    logic [W-1:0] m_mem [D];
    bit           m_pend[D];

    register_file_sb #(.WIDTH(W), .DEPTH(D), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_pend_a(rd_pend_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_pend_b(rd_pend_b),
        .pend_cnt(pend_cnt), .any_pend(any_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_data(input logic [A-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_pend(input logic [A-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return rsv_en && rsv_addr == a;
`endif
        return m_pend[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    // Advance one clock and apply the specification's rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                m_mem[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic check_ports(input string tag);
        #1;
        chk({tag, " rd_data_a"}, 32'(rd_data_a), 32'(exp_data(rd_addr_a)));
        chk({tag, " rd_pend_a"}, 32'(rd_pend_a), 32'(exp_pend(rd_addr_a)));
        chk({tag, " rd_data_b"}, 32'(rd_data_b), 32'(exp_data(rd_addr_b)));
        chk({tag, " rd_pend_b"}, 32'(rd_pend_b), 32'(exp_pend(rd_addr_b)));
        chk({tag, " pend_cnt"}, 32'(pend_cnt), 32'(exp_cnt()));
        chk({tag, " any_pend"}, 32'(any_pend), 32'(exp_cnt() != 0));
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic do_wr(input int a, input logic [W-1:0] d);
        idle(); wr_en = 1'b1; wr_addr = A'(a); wr_data = d; tick();
    endtask

    task automatic do_rsv(input int a);
        idle(); rsv_en = 1'b1; rsv_addr = A'(a); tick();
    endtask

    initial begin
        // Reset baseline after random writes, with rst held while reading.
        rst = 1'b1; tick();
        for (int i = 1; i < D; i++) do_wr(i, W'($urandom));
        do_rsv(3);
        rst = 1'b1; tick();
        for (int i = 0; i < D; i++) begin
            rd_addr_a = A'(i); rd_addr_b = A'(D - 1 - i);
            check_ports("reset");
            chk("reset rd_data_a const", 32'(rd_data_a), 32'h0);
        end
        chk("reset pend_cnt const", 32'(pend_cnt), 0);

        // Write and read back, then write to the hard-wired zero register.
        do_wr(3, 16'hA5A5); do_wr(7, 16'h1234); idle();
        rd_addr_a = 3; rd_addr_b = 7; check_ports("wr rb");
        chk("wr r3", 32'(rd_data_a), 32'hA5A5);
        chk("wr r7", 32'(rd_data_b), 32'h1234);
        do_rsv(0);
        do_wr(0, 16'hFFFF); idle();
        rd_addr_a = 0; check_ports("r0");
        chk("r0 data", 32'(rd_data_a), 32'h0);
        chk("r0 cnt", 32'(pend_cnt), 0);

        // Scoreboard count.
        rd_addr_a = 2;
        do_rsv(2); chk("cnt rsv2", 32'(pend_cnt), 1);
        do_rsv(4); chk("cnt rsv4", 32'(pend_cnt), 2);
        do_rsv(2); idle(); chk("cnt rsv2 again", 32'(pend_cnt), 2);
        #1 chk("pend a r2", 32'(rd_pend_a), 1);
        do_wr(2, 16'h00FF); idle(); check_ports("wr r2");
        chk("cnt after wr r2", 32'(pend_cnt), 1);
        chk("pend a r2 clr", 32'(rd_pend_a), 0);
        chk("data r2", 32'(rd_data_a), 32'h00FF);

        // Same-cycle reserve and write on r5.
        idle(); rsv_en = 1'b1; rsv_addr = 5; wr_en = 1'b1; wr_addr = 5; wr_data = 16'hBEEF;
        tick(); idle(); rd_addr_a = 5; check_ports("collide");
        chk("collide data", 32'(rd_data_a), 32'hBEEF);
        chk("collide pend", 32'(rd_pend_a), 1);
        chk("collide cnt", 32'(pend_cnt), 2);

        // Same-cycle write forwarding (or its absence) on r6.
        do_wr(6, 16'h1111);
        idle(); wr_en = 1'b1; wr_addr = 6; wr_data = 16'hC0DE; rd_addr_a = 6; rd_addr_b = 6;
        check_ports("bypass");
`ifdef REGFILE_BYPASS_EN
        chk("bypass same cycle", 32'(rd_data_a), 32'hC0DE);
`else
        chk("no bypass old", 32'(rd_data_a), 32'h1111);
`endif
        tick(); idle(); check_ports("bypass next");
        chk("bypass next cycle", 32'(rd_data_a), 32'hC0DE);

        // Mid-operation reset together with a write.
        do_wr(1, 16'h7777);
        do_rsv(1); do_rsv(3); do_rsv(5); idle();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 1; wr_data = 16'h5555;
        tick(); idle(); rd_addr_a = 1; rd_addr_b = 5; check_ports("mid reset");
        chk("mid reset cnt", 32'(pend_cnt), 0);
        chk("mid reset r1", 32'(rd_data_a), 32'h0);

        // Randomized traffic with small address space to force collisions.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            wr_en     = $urandom_range(0, 1) == 1;
            rsv_en    = $urandom_range(0, 2) != 0;
            wr_addr   = A'($urandom);
            rsv_addr  = A'($urandom);
            wr_data   = W'($urandom);
            rd_addr_a = A'($urandom);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : A'($urandom);
            check_ports("rand");
            tick();
        end
        idle(); check_ports("final");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
